lv_lbist_mc: RTL
================

// Module: lv_lbist_mc
// PURPOSE
// - Multi-channel LV logic BIST sequencer. Runs CH_NUM handshake sub-tests in order (ch0..CH_NUM-1),
//   e.g. owt tx loopback and scan-reg check. Each channel has a runtime request count and a pass threshold.
// - Sits in lv_top between the BIST enable source and the per-channel responders.
// - Reports per-channel fail flags, an overall pass flag and a done flag.
// PARAMETERS
// - CH_NUM  2   number of sub-test channels (>=1)
// - CNT_W   4   width of the per-channel request count and ok count
// - TMO_W   8   width of the ack timeout counter (used only with LV_LBIST_MC_TMO_EN)
// PORTS
// - i_clk             in   1             clock
// - i_rst_n           in   1             synchronous active-low reset
// - i_bist_en         in   1             level: 1 runs/holds the BIST; 0 aborts and clears
// - i_ch_req_num      in   CH_NUM*CNT_W  transactions per channel; field k = [k*CNT_W +: CNT_W]
// - i_ch_ok_min       in   CH_NUM*CNT_W  minimum error-free acks for channel k to pass
// - i_tmo_cyc         in   TMO_W         ack timeout in cycles (ignored without the macro)
// - o_ch_req          out  CH_NUM        request to channel k, registered, one-hot or zero
// - i_ch_ack          in   CH_NUM        ack from channel k, single-cycle pulse
// - i_ch_err          in   CH_NUM        error status of channel k, sampled only with its ack
// - o_ch_fail         out  CH_NUM        sticky per-channel fail flag
// - o_bist_done       out  1             all channels evaluated
// - o_bist_status     out  1             1 = all channels passed; valid while o_bist_done=1
// BEHAVIOUR
// - Reset (i_rst_n=0 at a clock edge): state IDLE; all outputs 0; all counters 0.
// - FSM states and transitions:
//   - IDLE: on i_bist_en=1, cur_ch=0 and go to LOAD.
//   - LOAD: if req_num[cur_ch]==0, go to EVAL. Otherwise go to WAIT; o_ch_req[cur_ch]=1 on the next cycle.
//   - WAIT: o_ch_req[cur_ch] held at 1.
//     - On i_ch_ack[cur_ch]=1: tx_cnt++, and ok_cnt++ if i_ch_err[cur_ch]=0.
//     - o_ch_req drops on the cycle after the ack.
//     - Next state is GAP if tx_cnt+1 < req_num, else EVAL.
//   - GAP: one cycle with req low, then WAIT (req high again).
//   - EVAL: o_ch_fail[cur_ch] = (ok_cnt < ok_min[cur_ch]); clear tx_cnt/ok_cnt.
//     - If cur_ch == CH_NUM-1, go to DONE; else cur_ch++ and go to LOAD.
//   - DONE: o_bist_done=1 and o_bist_status = ~|o_ch_fail, both held while i_bist_en=1.
// - Latency, no-stall case:
//   - en high to first req: 2 cycles.
//   - ack to next req of the same channel: 2 cycles.
//   - last ack to done of the final channel: 2 cycles.
// - Ack rules:
//   - An ack is counted only in WAIT on cur_ch.
//   - Acks on other channels, or in any other state, are ignored.
//   - At most one count per cycle.
// - req_num==0: channel is skipped. It passes if ok_min==0 and fails otherwise (ok_min > req_num always fails).
// - ok_cnt saturates at 2^CNT_W-1; it cannot exceed req_num.
// - i_bist_en=0 in any state: next cycle is IDLE; o_ch_req, o_ch_fail, o_bist_done, o_bist_status and counters all cleared.
// - i_bist_en re-asserted after DONE+drop: full rerun from ch0.
// - Config inputs are sampled per channel in LOAD/EVAL. Changing them mid-test affects only channels not yet loaded.
// - o_ch_req is one-hot or zero at all times.
// CONFIGURATION
// - LV_LBIST_MC_TMO_EN defined:
//   - In WAIT, tmo_cnt counts cycles without an ack.
//   - When tmo_cnt reaches i_tmo_cyc with no ack, treat it as an errored ack: tx_cnt++, ok_cnt unchanged, req drops.
//   - Then normal GAP/EVAL flow.
//   - tmo_cnt clears on entry to WAIT.
//   - i_tmo_cyc==0 disables the timeout.
// - LV_LBIST_MC_TMO_EN undefined: no timeout logic; WAIT holds indefinitely until ack or i_bist_en=0.
// TESTING
// - CH_NUM=2, req_num=4/4, ok_min=3/3, all acks err=0, ack 3 cycles after req
//   -> 8 req pulses (4 on ch0, then 4 on ch1); done=1, status=1, fail=2'b00.
// - Same config, ch1 acks 2 and 4 with err=1
//   -> fail=2'b10, status=0, done=1; ch0 unaffected.
// - i_bist_en dropped during ch1 WAIT
//   -> next cycle req=0, fail=0, done=0.
//   - re-enable: first req on ch0 after 2 cycles.
// - req_num[0]=0, ok_min[0]=0
//   -> ch0 never requested, fail[0]=0, ch1 runs normally.
//   - With ok_min[0]=1: fail[0]=1.
// - Stray acks: ch1 ack during ch0 WAIT, and ch0 ack in GAP
//   -> ignored; counts and req timing unchanged.
// - LV_LBIST_MC_TMO_EN, i_tmo_cyc=16, ch0 never acks, req_num=2, ok_min=1
//   -> req high 16 cycles, low 1, high 16; fail[0]=1, then ch1 runs.

Source files
------------

// File: rtl/lv_lbist_mc.sv
// Multi-channel LV logic BIST sequencer: walks channels 0..CH_NUM-1, issuing req/ack handshakes and grading ok counts.
// Latency: en->first req 2 cycles, ack->next req 2 cycles, last ack->done 2 cycles; WAIT stalls until ack (or timeout with LV_LBIST_MC_TMO_EN).
module lv_lbist_mc #(
    parameter int CH_NUM = 2,
    parameter int CNT_W  = 4,
    parameter int TMO_W  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_bist_en,
    input  logic [CH_NUM*CNT_W-1:0]   i_ch_req_num,
    input  logic [CH_NUM*CNT_W-1:0]   i_ch_ok_min,
    input  logic [TMO_W-1:0]          i_tmo_cyc,
    output logic [CH_NUM-1:0]         o_ch_req,
    input  logic [CH_NUM-1:0]         i_ch_ack,
    input  logic [CH_NUM-1:0]         i_ch_err,
    output logic [CH_NUM-1:0]         o_ch_fail,
    output logic                      o_bist_done,
    output logic                      o_bist_status
);

    localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_GAP  = 3'd3,
        S_EVAL = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_cur_ch;
    logic [CNT_W-1:0]    r_tx_cnt;
    logic [CNT_W-1:0]    r_ok_cnt;
    logic [CNT_W-1:0]    r_req_num;
    logic [CNT_W-1:0]    r_ok_min;
    logic [CH_NUM-1:0]   r_ch_req;
    logic [CH_NUM-1:0]   r_ch_fail;
    logic                r_done;

    logic [CNT_W-1:0]    w_req_num_sel;
    logic [CNT_W-1:0]    w_ok_min_sel;
    logic                w_ack;
    logic                w_err;
    logic                w_tmo;
    logic                w_last_ch;
    logic                w_more;
    logic [CH_NUM-1:0]   w_ch_req_nxt;
    logic                w_done_nxt;

    // Only the current channel's config and handshake are visible to the sequencer.
    always_comb begin
        w_req_num_sel = '0;
        w_ok_min_sel  = '0;
        w_ack         = 1'b0;
        w_err         = 1'b0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (r_cur_ch == CH_W'(k)) begin
                w_req_num_sel = i_ch_req_num[k*CNT_W +: CNT_W];
                w_ok_min_sel  = i_ch_ok_min[k*CNT_W +: CNT_W];
                w_ack         = i_ch_ack[k] && (r_state == S_WAIT);
                w_err         = i_ch_err[k];
            end
        end
    end

    assign w_last_ch = (r_cur_ch == CH_W'(CH_NUM - 1));
    assign w_more    = ({1'b0, r_tx_cnt} + (CNT_W+1)'(1)) < {1'b0, r_req_num};

`ifdef LV_LBIST_MC_TMO_EN
    logic [TMO_W-1:0] r_tmo_cnt;

    assign w_tmo = (r_state == S_WAIT) && !w_ack && (i_tmo_cyc != '0) &&
                   (r_tmo_cnt == i_tmo_cyc - TMO_W'(1));

    // Outside WAIT the counter sits at zero, so every WAIT entry starts a fresh window.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_WAIT && !w_ack && !w_tmo) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^i_tmo_cyc;
    assign w_tmo        = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!i_bist_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_LOAD;
                S_LOAD:  w_state_nxt = (w_req_num_sel == '0) ? S_EVAL : S_WAIT;
                S_WAIT:  if (w_ack || w_tmo) w_state_nxt = w_more ? S_GAP : S_EVAL;
                S_GAP:   w_state_nxt = S_WAIT;
                S_EVAL:  w_state_nxt = w_last_ch ? S_DONE : S_LOAD;
                S_DONE:  w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so req is glitch-free and one-hot.
    always_comb begin
        w_ch_req_nxt = '0;
        w_done_nxt   = (w_state_nxt == S_DONE);
        if (w_state_nxt == S_WAIT) begin
            for (int k = 0; k < CH_NUM; k++) begin
                w_ch_req_nxt[k] = (r_cur_ch == CH_W'(k));
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cur_ch  <= '0;
            r_tx_cnt  <= '0;
            r_ok_cnt  <= '0;
            r_req_num <= '0;
            r_ok_min  <= '0;
            r_ch_req  <= '0;
            r_ch_fail <= '0;
            r_done    <= 1'b0;
        end else if (!i_bist_en) begin
            r_cur_ch  <= '0;
            r_tx_cnt  <= '0;
            r_ok_cnt  <= '0;
            r_req_num <= '0;
            r_ok_min  <= '0;
            r_ch_req  <= '0;
            r_ch_fail <= '0;
            r_done    <= 1'b0;
        end else begin
            r_ch_req <= w_ch_req_nxt;
            r_done   <= w_done_nxt;
            case (r_state)
                S_IDLE: begin
                    r_cur_ch <= '0;
                end
                S_LOAD: begin
                    r_req_num <= w_req_num_sel;
                    r_ok_min  <= w_ok_min_sel;
                end
                S_WAIT: begin
                    if (w_ack) begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                        if (!w_err && r_ok_cnt != '1) begin
                            r_ok_cnt <= r_ok_cnt + CNT_W'(1);
                        end
                    end else if (w_tmo) begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                S_EVAL: begin
                    for (int k = 0; k < CH_NUM; k++) begin
                        if (r_cur_ch == CH_W'(k)) begin
                            r_ch_fail[k] <= (r_ok_cnt < r_ok_min);
                        end
                    end
                    r_tx_cnt <= '0;
                    r_ok_cnt <= '0;
                    if (!w_last_ch) begin
                        r_cur_ch <= r_cur_ch + CH_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ch_req      = r_ch_req;
    assign o_ch_fail     = r_ch_fail;
    assign o_bist_done   = r_done;
    assign o_bist_status = r_done & ~|r_ch_fail;

endmodule
